// File: rtl/bin_loader.sv
// ============================================================================
// Module   : bin_loader
// Brief    : Paper-tape BIN-format loader. Assembles 12-bit origin and data
//            words from 8-bit tape frames and writes data words into the
//            4Kx12 main memory. The last data word before the trailer is
//            treated as a checksum and is verified, not stored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  tape_data,
  input  logic        tape_valid,
  output logic        tape_ready,
  output logic [11:0] ram_addr,
  output logic [11:0] ram_data,
  output logic        ram_we,
  output logic        ram_oe,
  output logic        busy,
  output logic        done,
  output logic        cksum_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEADER = 3'd1,
    S_HI     = 3'd2,
    S_LO     = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  // Loader datapath registers
  logic [11:0] sum;
  logic [11:0] origin;
  logic [5:0]  hi6;
  logic        hi_orig;      // high frame was 01xxxxxx (origin word)
  logic        pend_valid;
  logic [11:0] pend_word;
  logic [11:0] pend_addr;
  logic [11:0] pend_fsum;
  logic        stage_valid;
  logic [11:0] stage_word;
  logic [11:0] stage_fsum;
  logic        cksum_err_r;

  // Frame classification and word assembly
  logic        xfer;
  logic        is_lead;
  logic        is_skip;
  logic        is_orig_hi;
  logic        is_low;
  logic        arm;
  logic [11:0] lo_word;
  logic [11:0] lo_fsum;

  assign xfer       = tape_valid && tape_ready;
  assign is_lead    = (tape_data == 8'h80);
  assign is_skip    = (tape_data[7:6] == 2'b11);   // rubout 0xFF is also 11xxxxxx
  assign is_orig_hi = (tape_data[7:6] == 2'b01);
  assign is_low     = (tape_data[7:6] == 2'b00);
  assign arm        = start && ((state == S_IDLE) || (state == S_DONE));
  assign lo_word    = {hi6, tape_data[5:0]};
  // Frame-byte sum of this word: rebuild the high frame byte from its class bit
  assign lo_fsum    = {4'b0000, 1'b0, hi_orig, hi6} + {6'b000000, tape_data[5:0]};

  assign ram_oe    = 1'b0;
  assign cksum_err = cksum_err_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    tape_ready = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = 12'd0;
    ram_data   = 12'd0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LEADER;
      end
      S_LEADER, S_HI: begin
        tape_ready = 1'b1;
        busy       = 1'b1;
        if (xfer) begin
          if (is_lead) begin
            // Leader frames are skipped; in HI the same frame is the trailer
            if (state == S_HI) state_nxt = S_DONE;
          end else if (is_orig_hi || is_low) begin
            state_nxt = S_LO;
          end
        end
      end
      S_LO: begin
        tape_ready = 1'b1;
        busy       = 1'b1;
        if (xfer) begin
          if (is_low) begin
            // Any completed word flushes an outstanding pending word
            state_nxt = pend_valid ? S_WRITE : S_HI;
          end else if (!is_skip) begin
            state_nxt = S_DONE;              // malformed low frame
          end
        end
      end
      S_WRITE: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = pend_addr;
        ram_data  = pend_word;
        state_nxt = S_HI;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_LEADER;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Word assembly, pending/staged word pipeline, checksum accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      sum         <= 12'd0;
      origin      <= 12'd0;
      hi6         <= 6'd0;
      hi_orig     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_word   <= 12'd0;
      pend_addr   <= 12'd0;
      pend_fsum   <= 12'd0;
      stage_valid <= 1'b0;
      stage_word  <= 12'd0;
      stage_fsum  <= 12'd0;
      cksum_err_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            sum         <= 12'd0;
            origin      <= 12'd0;
            pend_valid  <= 1'b0;
            stage_valid <= 1'b0;
            cksum_err_r <= 1'b0;
          end
        end
        S_LEADER, S_HI: begin
          if (xfer) begin
            if (is_lead) begin
              // The pending word at the trailer is the checksum
              if (state == S_HI) cksum_err_r <= pend_valid && (pend_word != sum);
            end else if (is_orig_hi || is_low) begin
              hi6     <= tape_data[5:0];
              hi_orig <= is_orig_hi;
            end
          end
        end
        S_LO: begin
          if (xfer) begin
            if (is_low) begin
              if (hi_orig) begin
                sum    <= sum + lo_fsum;
                origin <= lo_word;
              end else if (!pend_valid) begin
                pend_valid <= 1'b1;
                pend_word  <= lo_word;
                pend_addr  <= origin;
                pend_fsum  <= lo_fsum;
                origin     <= origin + 12'd1;
              end else begin
                stage_valid <= 1'b1;
                stage_word  <= lo_word;
                stage_fsum  <= lo_fsum;
              end
            end else if (!is_skip) begin
              cksum_err_r <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          // The word being written is now known not to be the checksum
          sum <= sum + pend_fsum;
          if (stage_valid) begin
            pend_word   <= stage_word;
            pend_fsum   <= stage_fsum;
            pend_addr   <= origin;
            origin      <= origin + 12'd1;
            stage_valid <= 1'b0;
          end else begin
            pend_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin_loader.sv
// ============================================================================
// Module   : tb_bin_loader
// Brief    : Directed self-checking bench for bin_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  tape_data;
  logic        tape_valid;
  logic        tape_ready;
  logic [11:0] ram_addr;
  logic [11:0] ram_data;
  logic        ram_we;
  logic        ram_oe;
  logic        busy;
  logic        done;
  logic        cksum_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] wa[$];
  logic [11:0] wd[$];

  bin_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tape_data  (tape_data),
    .tape_valid (tape_valid),
    .tape_ready (tape_ready),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .ram_oe     (ram_oe),
    .busy       (busy),
    .done       (done),
    .cksum_err  (cksum_err)
  );

  always #5 clk = ~clk;

  // Record every RAM write, sampled mid-cycle
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wa.push_back(ram_addr);
      wd.push_back(ram_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one frame after an optional idle gap; returns just after it is taken
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    tape_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    tape_data  = b;
    tape_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (tape_ready === 1'b1) break;
      n++;
      if (n > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: frame %h, tape_ready %b, required 1", b, tape_ready);
        break;
      end
    end
    @(posedge clk); #1;
    tape_valid = 1'b0;
  endtask

  task automatic leader(input int n);
    repeat (n) send(8'h80, 0);
  endtask

  task automatic start_load();
    wa.delete();
    wd.delete();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (done !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: done %b, required 1", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tape_valid = 1'b0; tape_data = 8'h00;
    tick(3);
    @(negedge clk);
    n_checks++;
    if ({tape_ready, ram_we, ram_oe, busy, done, cksum_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 000000",
               {tape_ready, ram_we, ram_oe, busy, done, cksum_err});
    end
    n_checks++;
    if ({ram_addr, ram_data} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_bus: addr %o data %o, required 0 0", ram_addr, ram_data);
    end
    @(posedge clk); #1; reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    start_load();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_after_start: busy %b done %b, required 1 0", busy, done);
    end
    leader(4);
    send(8'h42, 0); send(8'h00, 0); send(8'h3C, 0); send(8'h02, 0); send(8'h02, 0);
    send(8'h00, 0);
    // Low frame of the checksum word just accepted: this is the WRITE cycle
    n_checks++;
    if (ram_we !== 1'b1 || ram_addr !== 12'o0200 || ram_data !== 12'o7402 || tape_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_write_cycle: we %b addr %o data %o rdy %b, required 1 0200 7402 0",
               ram_we, ram_addr, ram_data, tape_ready);
    end
    send(8'h80, 0);
    wait_done();
    // Second trailer frame must not be taken
    tape_data = 8'h80; tape_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tape_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_ready_in_done: tape_ready %b, required 0", tape_ready);
    end
    tape_valid = 1'b0;
    n_checks++;
    if (wa.size() != 1) begin
      n_fail++; $display("FAIL basic_write_count: got %0d, required 1", wa.size());
    end else if (wa[0] !== 12'o0200 || wd[0] !== 12'o7402) begin
      n_fail++; $display("FAIL basic_write: addr %o data %o, required 0200 7402", wa[0], wd[0]);
    end
    n_checks++;
    if (done !== 1'b1 || cksum_err !== 1'b0 || busy !== 1'b0 || ram_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: done %b err %b busy %b oe %b, required 1 0 0 0",
               done, cksum_err, busy, ram_oe);
    end
  endtask

  task automatic test_bad_cksum();
    start_load();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bad_restart: done %b busy %b, required 0 1", done, busy);
    end
    leader(2);
    send(8'h42, 0); send(8'h00, 0); send(8'h3C, 0); send(8'h02, 0); send(8'h02, 0);
    send(8'h01, 0); send(8'h80, 0);
    wait_done();
    n_checks++;
    if (wa.size() != 1) begin
      n_fail++; $display("FAIL bad_write_count: got %0d, required 1", wa.size());
    end else if (wa[0] !== 12'o0200 || wd[0] !== 12'o7402) begin
      n_fail++; $display("FAIL bad_write: addr %o data %o, required 0200 7402", wa[0], wd[0]);
    end
    n_checks++;
    if (done !== 1'b1 || cksum_err !== 1'b1) begin
      n_fail++; $display("FAIL bad_status: done %b err %b, required 1 1", done, cksum_err);
    end
  endtask

  task automatic test_gaps();
    logic [11:0] ea [3];
    logic [11:0] ed [3];
    ea[0] = 12'o0200; ea[1] = 12'o0201; ea[2] = 12'o0202;
    ed[0] = 12'o0001; ed[1] = 12'o0002; ed[2] = 12'o0003;
    start_load();
    n_checks++;
    if (cksum_err !== 1'b0) begin
      n_fail++; $display("FAIL gaps_err_cleared: err %b, required 0", cksum_err);
    end
    leader(2);
    send(8'hFF, 1); send(8'h42, 2); send(8'hC0, 0); send(8'h00, 3);
    send(8'h00, 1); send(8'hFF, 0); send(8'h01, 2);
    send(8'h00, 0); send(8'hC0, 3); send(8'h02, 1);
    send(8'h00, 2); send(8'h03, 0); send(8'hFF, 1);
    send(8'h01, 3); send(8'hC0, 0); send(8'h08, 2);
    send(8'h80, 1);
    wait_done();
    n_checks++;
    if (wa.size() != 3) begin
      n_fail++; $display("FAIL gaps_write_count: got %0d, required 3", wa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          n_fail++;
          $display("FAIL gaps_write%0d: addr %o data %o, required %o %o", i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
    n_checks++;
    if (cksum_err !== 1'b0) begin
      n_fail++; $display("FAIL gaps_cksum: err %b, required 0", cksum_err);
    end
  endtask

  task automatic test_wrap();
    start_load();
    leader(1);
    send(8'h7F, 0); send(8'h3F, 0);   // origin 7777
    send(8'h00, 0); send(8'h05, 0);
    send(8'h00, 0); send(8'h06, 0);
    send(8'h03, 0); send(8'h09, 0);   // checksum 0xBE+0x05+0x06 = 0x0C9
    send(8'h80, 0);
    wait_done();
    n_checks++;
    if (wa.size() != 2) begin
      n_fail++; $display("FAIL wrap_write_count: got %0d, required 2", wa.size());
    end else if (wa[0] !== 12'o7777 || wd[0] !== 12'o0005 || wa[1] !== 12'o0000 || wd[1] !== 12'o0006) begin
      n_fail++;
      $display("FAIL wrap_writes: %o=%o %o=%o, required 7777=0005 0000=0006", wa[0], wd[0], wa[1], wd[1]);
    end
    n_checks++;
    if (cksum_err !== 1'b0) begin
      n_fail++; $display("FAIL wrap_cksum: err %b, required 0", cksum_err);
    end
  endtask

  task automatic test_origin_mid();
    start_load();
    leader(1);
    send(8'h42, 0); send(8'h00, 0);   // origin 0200
    send(8'h00, 0); send(8'h11, 0);   // data 0021
    send(8'h43, 0); send(8'h00, 0);   // origin 0300
    send(8'h00, 0); send(8'h22, 0);   // data 0042
    send(8'h02, 0); send(8'h38, 0);   // checksum 0x0B8
    send(8'h80, 0);
    wait_done();
    n_checks++;
    if (wa.size() != 2) begin
      n_fail++; $display("FAIL orgmid_write_count: got %0d, required 2", wa.size());
    end else if (wa[0] !== 12'o0200 || wd[0] !== 12'h011 || wa[1] !== 12'o0300 || wd[1] !== 12'h022) begin
      n_fail++;
      $display("FAIL orgmid_writes: %o=%h %o=%h, required 0200=011 0300=022", wa[0], wd[0], wa[1], wd[1]);
    end
    n_checks++;
    if (cksum_err !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL orgmid_status: err %b done %b, required 0 1", cksum_err, done);
    end
  endtask

  task automatic test_reset_mid();
    start_load();
    leader(1);
    send(8'h42, 0); send(8'h00, 0); send(8'h3C, 0); send(8'h02, 0);
    send(8'h02, 0);                   // high frame taken, pending word outstanding
    reset = 1'b1; tape_data = 8'h00; tape_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tape_ready, ram_we, ram_oe, busy, done, cksum_err} !== 6'b0 || {ram_addr, ram_data} !== 24'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: flags %b addr %o data %o, required 000000 0 0",
               {tape_ready, ram_we, ram_oe, busy, done, cksum_err}, ram_addr, ram_data);
    end
    repeat (5) @(negedge clk);
    tape_valid = 1'b0;
    n_checks++;
    if (wa.size() != 0) begin
      n_fail++; $display("FAIL rstmid_no_write: got %0d writes, required 0", wa.size());
    end
  endtask

  task automatic test_format_err();
    start_load();
    leader(1);
    send(8'h42, 0); send(8'h00, 0); send(8'h3C, 0); send(8'h02, 0);
    send(8'h02, 0); send(8'h80, 0);   // trailer where a low frame belongs
    wait_done();
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || cksum_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL fmt_status: done %b err %b busy %b, required 1 1 0", done, cksum_err, busy);
    end
    n_checks++;
    if (wa.size() != 0) begin
      n_fail++; $display("FAIL fmt_no_write: got %0d writes, required 0", wa.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_cksum();
    test_gaps();
    test_wrap();
    test_origin_mid();
    test_reset_mid();
    test_format_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
